// File: rtl/apb_master_unit_if.sv
// apb_master_unit_if: command/response handshake plus APB3 request/completion.
// master modport = requester view (apb_master_unit), slave = driver/slave view.
interface apb_master_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [DATA_WIDTH-1:0] cmd_wdata_i;

  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic [DATA_WIDTH-1:0] resp_rdata_o;
  logic                  resp_err_o;

  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic                  pwrite_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pready_i;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  pslverr_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
    output cmd_ready_o,
    output resp_valid_o, resp_rdata_o, resp_err_o,
    input  resp_ready_i,
    output paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
    input  pready_i, prdata_i, pslverr_i
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
    input  cmd_ready_o,
    input  resp_valid_o, resp_rdata_o, resp_err_o,
    output resp_ready_i,
    input  paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
    output pready_i, prdata_i, pslverr_i
  );
endinterface

// File: rtl/apb_master_unit.sv
// apb_master_unit: single-beat APB3 requester, one transfer in flight.
// Ports: clk, reset (sync, active-high), bus (apb_master_unit_if.master:
// cmd_* request, resp_* response, p* APB). Optional ACCESS watchdog
// enabled by defining APB_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module apb_master_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  apb_master_unit_if.master   bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

`ifdef APB_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d, cnt_inc;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef APB_TIMEOUT_EN
    cnt_d   = cnt_q;
    // saturating: never wraps back below the limit
    cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          addr_d  = bus.cmd_addr_i;
          wdata_d = bus.cmd_wdata_i;
          write_d = bus.cmd_write_i;
          state_d = S_SETUP;
`ifdef APB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // pready wins over a same-cycle timeout
        if (bus.pready_i) begin
          rdata_d = write_q ? '0 : bus.prdata_i;
          err_d   = bus.pslverr_i;
          state_d = S_RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_inc >= TO_LIM) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      S_RESP: begin
        if (bus.resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.cmd_ready_o  = (state_q == S_IDLE);
  assign bus.psel_o       = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign bus.penable_o    = (state_q == S_ACCESS);
  assign bus.resp_valid_o = (state_q == S_RESP);
  assign bus.resp_rdata_o = rdata_q;
  assign bus.resp_err_o   = err_q;
  assign bus.paddr_o      = addr_q;
  assign bus.pwdata_o     = wdata_q;
  assign bus.pwrite_o     = write_q;

endmodule

// File: tb/tb_apb_master_unit.sv
// tb_apb_master_unit: directed stimulus, transaction-level timing model
// compared every cycle, plus literal expectations at key cycles.
module tb_apb_master_unit;
  localparam int TO = 16;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  apb_master_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  apb_master_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a transfer is described by its age (edges since accept) and
  // the age at which its ACCESS ended (-1 while still open).
  bit          m_live;
  bit          m_busy;
  int          m_age;
  int          m_end;
  int          m_wait;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_write, m_err;

  initial begin
    m_live = 0; m_busy = 0; m_age = 0; m_end = -1; m_wait = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1; m_busy = 0;
      m_addr = 0; m_wdata = 0; m_write = 0;
      m_rdata = 0; m_err = 0;
    end else if (!m_busy) begin
      if (bus.cmd_valid_i) begin
        m_busy = 1; m_age = 1; m_end = -1; m_wait = 0;
        m_addr = bus.cmd_addr_i;
        m_wdata = bus.cmd_wdata_i;
        m_write = bus.cmd_write_i;
      end
    end else if (m_end < 0 && m_age >= 2) begin
      if (bus.pready_i) begin
        m_rdata = m_write ? 32'd0 : bus.prdata_i;
        m_err = bus.pslverr_i;
        m_end = m_age;
      end else begin
        m_wait++;
`ifdef APB_TIMEOUT_EN
        if (m_wait >= TO) begin
          m_rdata = 0; m_err = 1; m_end = m_age;
        end
`endif
      end
      m_age++;
    end else if (m_end >= 0) begin
      if (bus.resp_ready_i) m_busy = 0;
      m_age++;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    logic e_psel, e_pen, e_rv, e_cr, ok;
    if (m_live) begin
      e_psel = m_busy && (m_end < 0);
      e_pen  = e_psel && (m_age >= 2);
      e_rv   = m_busy && (m_end >= 0);
      e_cr   = !m_busy;
      ok = (bus.psel_o === e_psel) && (bus.penable_o === e_pen) &&
           (bus.resp_valid_o === e_rv) && (bus.cmd_ready_o === e_cr) &&
           (bus.paddr_o === m_addr) && (bus.pwdata_o === m_wdata) &&
           (bus.pwrite_o === m_write);
      if (e_rv)
        ok = ok && (bus.resp_rdata_o === m_rdata) &&
             (bus.resp_err_o === m_err);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL model t=%0t act sel/en/rv/cr=%b%b%b%b addr=%h wd=%h w=%b rd=%h e=%b req sel/en/rv/cr=%b%b%b%b addr=%h wd=%h w=%b rd=%h e=%b",
                 $time, bus.psel_o, bus.penable_o, bus.resp_valid_o,
                 bus.cmd_ready_o, bus.paddr_o, bus.pwdata_o, bus.pwrite_o,
                 bus.resp_rdata_o, bus.resp_err_o, e_psel, e_pen, e_rv,
                 e_cr, m_addr, m_wdata, m_write, m_rdata, m_err);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic cmd(input logic w, input logic [31:0] a,
                     input logic [31:0] d);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = w;
    bus.cmd_addr_i  = a;
    bus.cmd_wdata_i = d;
  endtask

  task automatic handshake();
    bus.resp_ready_i = 1'b1;
    cyc();
    bus.resp_ready_i = 1'b0;
  endtask

  initial begin
    int n;
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.cmd_valid_i = 0; bus.cmd_write_i = 0;
    bus.cmd_addr_i = 0; bus.cmd_wdata_i = 0;
    bus.resp_ready_i = 0; bus.pready_i = 0;
    bus.prdata_i = 0; bus.pslverr_i = 0;
    repeat (3) cyc();
    smp();
    chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("rst_psel", 32'(bus.psel_o), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("rst_paddr", bus.paddr_o, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();

    // zero-wait write
    cmd(1'b1, 32'h4, 32'h12345678);
    bus.pready_i = 1'b1;
    cyc();
    bus.cmd_valid_i = 1'b0;
    smp();
    chk("w0_setup_psel", 32'(bus.psel_o), 32'd1);
    chk("w0_setup_pen", 32'(bus.penable_o), 32'd0);
    chk("w0_paddr", bus.paddr_o, 32'h4);
    chk("w0_pwrite", 32'(bus.pwrite_o), 32'd1);
    chk("w0_pwdata", bus.pwdata_o, 32'h12345678);
    cyc(); smp();
    chk("w0_access_pen", 32'(bus.penable_o), 32'd1);
    cyc(); smp();
    chk("w0_resp_valid", 32'(bus.resp_valid_o), 32'd1);
    chk("w0_resp_err", 32'(bus.resp_err_o), 32'd0);
    chk("w0_resp_rdata", bus.resp_rdata_o, 32'd0);
    cyc();
    handshake();

    // read, three wait states
    cmd(1'b0, 32'h3, 32'hFFFF0000);
    bus.pready_i = 1'b0;
    cyc();
    bus.cmd_valid_i = 1'b0;
    repeat (4) cyc();
    bus.pready_i = 1'b1;
    bus.prdata_i = 32'hDEADBEEF;
    smp();
    chk("r3_t5_pen", 32'(bus.penable_o), 32'd1);
    chk("r3_t5_rv", 32'(bus.resp_valid_o), 32'd0);
    cyc();
    bus.pready_i = 1'b0;
    bus.prdata_i = 32'h0;
    smp();
    chk("r3_t6_rv", 32'(bus.resp_valid_o), 32'd1);
    chk("r3_rdata", bus.resp_rdata_o, 32'hDEADBEEF);
    cyc();
    handshake();

    // write with slave error, then a read right after the handshake
    cmd(1'b1, 32'h8, 32'hA5A5A5A5);
    bus.pready_i = 1'b1;
    bus.pslverr_i = 1'b1;
    cyc();
    bus.cmd_valid_i = 1'b0;
    cyc(); cyc(); smp();
    chk("err_resp_err", 32'(bus.resp_err_o), 32'd1);
    bus.pslverr_i = 1'b0;
    bus.prdata_i = 32'h55AA55AA;
    cmd(1'b0, 32'h10, 32'h0);
    handshake();
    smp();
    chk("err_next_ready", 32'(bus.cmd_ready_o), 32'd1);
    cyc();
    bus.cmd_valid_i = 1'b0;
    smp();
    chk("err_next_psel", 32'(bus.psel_o), 32'd1);
    chk("err_next_paddr", bus.paddr_o, 32'h10);
    cyc(); cyc(); smp();
    chk("err_next_rdata", bus.resp_rdata_o, 32'h55AA55AA);

    // response stall with a pending command
    cmd(1'b1, 32'h20, 32'hCAFE);
    for (int i = 0; i < 5; i++) begin
      cyc(); smp();
      chk("stall_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
      chk("stall_psel", 32'(bus.psel_o), 32'd0);
      chk("stall_rdata", bus.resp_rdata_o, 32'h55AA55AA);
    end
    cyc();
    handshake();
    smp();
    chk("stall_after_ready", 32'(bus.cmd_ready_o), 32'd1);
    cyc();
    bus.cmd_valid_i = 1'b0;
    smp();
    chk("stall_next_paddr", bus.paddr_o, 32'h20);
    cyc(); cyc();
    handshake();

    // slave never ready
    cmd(1'b0, 32'h40, 32'h0);
    bus.pready_i = 1'b0;
    bus.prdata_i = 32'h77;
    cyc();
    bus.cmd_valid_i = 1'b0;
    repeat (100) cyc();
    smp();
`ifdef APB_TIMEOUT_EN
    chk("to_resp_valid", 32'(bus.resp_valid_o), 32'd1);
    chk("to_resp_err", 32'(bus.resp_err_o), 32'd1);
    chk("to_rdata", bus.resp_rdata_o, 32'd0);
    chk("to_psel", 32'(bus.psel_o), 32'd0);
`else
    chk("hang_psel", 32'(bus.psel_o), 32'd1);
    chk("hang_pen", 32'(bus.penable_o), 32'd1);
`endif
    bus.pready_i = 1'b1;
    n = 0;
    while (!bus.resp_valid_o && n < 20) begin
      cyc();
      n++;
    end
    chk("hang_resp_seen", 32'(bus.resp_valid_o), 32'd1);
    bus.pready_i = 1'b0;
    handshake();

    // reset during ACCESS, late pready ignored
    cmd(1'b1, 32'h80, 32'h1111);
    cyc();
    bus.cmd_valid_i = 1'b0;
    cyc(); smp();
    chk("rsta_pen", 32'(bus.penable_o), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    smp();
    chk("rsta_psel", 32'(bus.psel_o), 32'd0);
    chk("rsta_pen0", 32'(bus.penable_o), 32'd0);
    chk("rsta_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("rsta_rv", 32'(bus.resp_valid_o), 32'd0);
    bus.pready_i = 1'b1;
    repeat (3) cyc();
    smp();
    chk("rsta_late_rv", 32'(bus.resp_valid_o), 32'd0);
    chk("rsta_late_psel", 32'(bus.psel_o), 32'd0);
    bus.pready_i = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
